// File: rtl/tinyrisc_mem_pkg.sv
// Shared definitions for the TinyRisc data-memory access unit:
// size encodings, access FSM states, lane-enable and load-extract helpers.
package tinyrisc_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Little-endian lane enables; callers must have rejected misaligned accesses.
  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] en;
    en = 4'b0000;
    case (sz)
      SZ_BYTE: en = 4'b0001 << off;
      SZ_HALF: en = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  function automatic logic [31:0] st_replicate(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    case (sz)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ld_extract(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] shb;
    logic [31:0] shh;
    logic [31:0] r;
    shb = word >> {off, 3'b000};
    shh = word >> {off[1], 4'b0000};
    r   = word;
    case (sz)
      SZ_BYTE: r = uns ? {24'd0, shb[7:0]}  : {{24{shb[7]}}, shb[7:0]};
      SZ_HALF: r = uns ? {16'd0, shh[15:0]} : {{16{shh[15]}}, shh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bytewise.sv
// DEPTH x 32 data memory with per-byte write enables, synchronous write
// and combinational read. Contents are never reset.
module dmem_bytewise #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic [3:0]       we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 4; l++) begin
      if (we_i[l]) mem_q[idx_i][8*l +: 8] <= wdata_i[8*l +: 8];
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_access_unit_pipe.sv
// TinyRisc data-memory access unit: latches one request, waits LATENCY
// cycles, performs the byte/half/word access and pulses resp_valid.
module mem_access_unit_pipe
  import tinyrisc_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              isLd,
  input  logic              isSt,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] aluResult,
  input  logic [31:0]       op2,
  output logic              resp_valid,
  output logic [31:0]       ldresult,
  output logic              err,
  output logic              busy
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept, commit;

  logic              is_ld_q, is_st_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       op2_q;

  logic [31:0]       ldresult_q;
  logic              err_q;
  logic              oor, err_c;
  logic [3:0]        we;
  logic [31:0]       wdata, rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && (isLd || isSt)) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      ldresult_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= commit && err_c;
      if (commit && is_ld_q && !err_c)
        ldresult_q <= ld_extract(rdata, size_q, addr_q[1:0], uns_q);
    end
  end

  // Request fields are captured only on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_ld_q <= isLd;
      is_st_q <= isSt;
      size_q  <= size;
      uns_q   <= ld_unsigned;
      addr_q  <= aluResult;
      op2_q   <= op2;
    end
  end

  // With DEPTH a power of two, any set bit above the word index is out of range.
  if (ADDR_W - 2 > IDX_W) begin : g_oor
    assign oor = |addr_q[ADDR_W-1:IDX_W+2];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  assign err_c = (is_ld_q && is_st_q)
              || (size_q == 2'd3)
              || (size_q == SZ_HALF && addr_q[0])
              || (size_q == SZ_WORD && addr_q[1:0] != 2'b00)
              || oor;

  // A write committing on the same edge as rst is deliberately not blocked.
  assign we    = (commit && is_st_q && !err_c) ? byte_en(size_q, addr_q[1:0]) : 4'b0000;
  assign wdata = st_replicate(size_q, op2_q);

  dmem_bytewise #(.DEPTH(DEPTH)) u_dmem (
    .clk_i   (clk),
    .we_i    (we),
    .idx_i   (addr_q[IDX_W+1:2]),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_WAIT);
  assign resp_valid = (state_q == ST_RESP);
  assign ldresult   = ldresult_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_access_unit_pipe.sv
// Directed bench for mem_access_unit_pipe: one instance with LATENCY=1 and
// one with LATENCY=4 share stimulus, selected by sel.
module tb_mem_access_unit_pipe;

  localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, isLd = 1'b0, isSt = 1'b0, ld_unsigned = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] aluResult = 32'd0, op2 = 32'd0;

  logic        rv_in1, rv_in4;
  logic        rdy1, rdy4, rv1, rv4, err1, err4, busy1, busy4;
  logic [31:0] ld1, ld4;
  logic        rdy, rv, err_o, busy;
  logic [31:0] ldr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign rv_in1 = req_valid & ~sel;
  assign rv_in4 = req_valid & sel;
  assign rdy    = sel ? rdy4  : rdy1;
  assign rv     = sel ? rv4   : rv1;
  assign err_o  = sel ? err4  : err1;
  assign busy   = sel ? busy4 : busy1;
  assign ldr    = sel ? ld4   : ld1;

  mem_access_unit_pipe #(.DEPTH(64), .LATENCY(1), .ADDR_W(32)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(rv_in1), .req_ready(rdy1), .isLd(isLd), .isSt(isSt),
    .size(size), .ld_unsigned(ld_unsigned), .aluResult(aluResult), .op2(op2),
    .resp_valid(rv1), .ldresult(ld1), .err(err1), .busy(busy1));

  mem_access_unit_pipe #(.DEPTH(64), .LATENCY(4), .ADDR_W(32)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(rv_in4), .req_ready(rdy4), .isLd(isLd), .isSt(isSt),
    .size(size), .ld_unsigned(ld_unsigned), .aluResult(aluResult), .op2(op2),
    .resp_valid(rv4), .ldresult(ld4), .err(err4), .busy(busy4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                     input logic uns, input logic [31:0] addr, input logic [31:0] data,
                     input logic exp_err, input logic chk_data, input logic [31:0] exp_data);
    int w;
    int lat;
    w = 0;
    @(negedge clk);
    while (!rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b1; isLd = ld; isSt = st; size = sz;
    ld_unsigned = uns; aluResult = addr; op2 = data;
    @(posedge clk); #1;
    req_valid = 1'b0; isLd = 1'b0; isSt = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rv && lat < 50);
    check({tag, "_lat"}, 32'(lat), sel ? 32'd4 : 32'd1);
    check({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
    if (chk_data) check({tag, "_data"}, ldr, exp_data);
  endtask

  int nrdy, nbusy, nrv, w;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_resp_valid", {31'd0, rv}, 32'd0);
    check("rst_ldresult", ldr, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, rdy}, 32'd1);

    // LATENCY = 1
    run("st10", 0, 1, W, 0, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0);
    run("ld10", 1, 0, W, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF);
    run("st20", 0, 1, W, 0, 32'h20, 32'h80FF7F01, 0, 0, 32'h0);
    run("lb21", 1, 0, B, 0, 32'h21, 32'h0, 0, 1, 32'h0000007F);
    run("lb23", 1, 0, B, 0, 32'h23, 32'h0, 0, 1, 32'hFFFFFF80);
    run("lbu23", 1, 0, B, 1, 32'h23, 32'h0, 0, 1, 32'h00000080);
    run("lhu22", 1, 0, H, 1, 32'h22, 32'h0, 0, 1, 32'h000080FF);
    run("lh22", 1, 0, H, 0, 32'h22, 32'h0, 0, 1, 32'hFFFF80FF);
    run("lwu20", 1, 0, W, 1, 32'h20, 32'h0, 0, 1, 32'h80FF7F01);
    run("st30", 0, 1, W, 0, 32'h30, 32'h11223344, 0, 0, 32'h0);
    run("sb31", 0, 1, B, 0, 32'h31, 32'h123456AB, 0, 0, 32'h0);
    run("sh32", 0, 1, H, 0, 32'h32, 32'h9999CDEF, 0, 0, 32'h0);
    run("ld30", 1, 0, W, 0, 32'h30, 32'h0, 0, 1, 32'hCDEFAB44);
    run("st40", 0, 1, W, 0, 32'h40, 32'h01020304, 0, 0, 32'h0);
    run("e_lh41", 1, 0, H, 0, 32'h41, 32'h0, 1, 1, 32'hCDEFAB44);
    run("e_sw42", 0, 1, W, 0, 32'h42, 32'hFFFFFFFF, 1, 0, 32'h0);
    run("e_lw100", 1, 0, W, 0, 32'h100, 32'h0, 1, 1, 32'hCDEFAB44);
    run("e_sz3", 0, 1, 2'd3, 0, 32'h40, 32'hFFFFFFFF, 1, 0, 32'h0);
    run("e_ldst", 1, 1, W, 0, 32'h40, 32'hFFFFFFFF, 1, 1, 32'hCDEFAB44);
    run("ld40", 1, 0, W, 0, 32'h40, 32'h0, 0, 1, 32'h01020304);

    // request with neither load nor store is ignored
    @(negedge clk);
    req_valid = 1'b1; isLd = 1'b0; isSt = 1'b0;
    @(posedge clk); #1;
    check("nop_ready", {31'd0, rdy}, 32'd1);
    check("nop_busy", {31'd0, busy}, 32'd0);
    req_valid = 1'b0;

    // LATENCY = 4: request held high while busy, fields changed after accept
    sel = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; isLd = 1'b0; isSt = 1'b1; size = W; aluResult = 32'h60; op2 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    isLd = 1'b1; isSt = 1'b0; op2 = 32'h0;
    nrdy = 0; nbusy = 0; nrv = 0;
    for (int k = 0; k < 5; k++) begin
      if (!rdy) nrdy++;
      if (busy) nbusy++;
      if (rv) nrv++;
      @(posedge clk); #1;
    end
    check("l4_ready_low", 32'(nrdy), 32'd5);
    check("l4_busy_high", 32'(nbusy), 32'd4);
    check("l4_resp_once", 32'(nrv), 32'd1);
    check("l4_idle_ready", {31'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    check("l4_held_accept", {31'd0, busy}, 32'd1);
    req_valid = 1'b0; isLd = 1'b0;
    w = 0;
    while (!rv && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("l4_held_ld", ldr, 32'hA5A5A5A5);

    // reset during the second WAIT cycle drops the byte store
    run("st50", 0, 1, W, 0, 32'h50, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; isSt = 1'b1; isLd = 1'b0; size = B; aluResult = 32'h50; op2 = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0; isSt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_resp_valid", {31'd0, rv}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_ready", {31'd0, rdy}, 32'd1);
    check("mrst_err", {31'd0, err_o}, 32'd0);
    check("mrst_ldresult", ldr, 32'd0);
    nrv = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (rv) nrv++;
    end
    check("mrst_no_resp", 32'(nrv), 32'd0);
    run("ld50", 1, 0, W, 0, 32'h50, 32'h0, 0, 1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
